// File: rtl/gpu_xform_pkg.sv
// Shared types and constants for the vertex transform scheduler.
// Coordinates are signed Q1.10.10, angles signed Q1.2.13 radians.
package gpu_xform_pkg;

    localparam int CW      = 21;
    localparam int AW      = 16;
    localparam int NUM_VTX = 4;
    localparam int TO_CYC  = 64;

    localparam int CW_INT  = 10;
    localparam int CW_FRAC = 10;
    localparam int AW_INT  = 2;
    localparam int AW_FRAC = 13;
    localparam logic [CW-1:0] Q_COORD_ONE = CW'(1 << CW_FRAC);
    localparam logic [AW-1:0] Q_ANGLE_ONE = AW'(1 << AW_FRAC);

    localparam int IW   = ($clog2(NUM_VTX) < 1) ? 1 : $clog2(NUM_VTX);
    localparam int CNTW = $clog2(NUM_VTX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xf_state_e;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } coord_t;

    typedef struct packed {
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [AW-1:0] z;
    } angle_t;

endpackage

// File: rtl/xf_watchdog.sv
// Stall watchdog for the transform scheduler; only built when XF_TIMEOUT_EN is defined.
// Counts enabled cycles since the last clear and flags expiry on the LIMIT-th cycle.
`ifdef XF_TIMEOUT_EN
module xf_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire = enable && !clear && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
`endif

// File: rtl/vertex_xform_sched.sv
// Per-frame scheduler: snapshots pose and vertices, issues them to the xform unit in order,
// collects in-order results and publishes a whole frame at once. Optional watchdog: XF_TIMEOUT_EN.
module vertex_xform_sched
    import gpu_xform_pkg::*;
(
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [CW-1:0]         Xc,
    input  logic [CW-1:0]         Yc,
    input  logic [CW-1:0]         Zc,
    input  logic [AW-1:0]         angleX,
    input  logic [AW-1:0]         angleY,
    input  logic [AW-1:0]         angleZ,
    input  logic [NUM_VTX*CW-1:0] vtx_X,
    input  logic [NUM_VTX*CW-1:0] vtx_Y,
    input  logic [NUM_VTX*CW-1:0] vtx_Z,
    output logic                  xf_valid,
    input  logic                  xf_ready,
    output logic [IW-1:0]         xf_idx,
    output logic [CW-1:0]         xf_vX,
    output logic [CW-1:0]         xf_vY,
    output logic [CW-1:0]         xf_vZ,
    output logic [CW-1:0]         xf_cX,
    output logic [CW-1:0]         xf_cY,
    output logic [CW-1:0]         xf_cZ,
    output logic [AW-1:0]         xf_aX,
    output logic [AW-1:0]         xf_aY,
    output logic [AW-1:0]         xf_aZ,
    input  logic                  res_valid,
    input  logic [IW-1:0]         res_idx,
    input  logic [CW-1:0]         res_X,
    input  logic [CW-1:0]         res_Y,
    input  logic [CW-1:0]         res_Z,
    output logic [NUM_VTX*CW-1:0] out_X,
    output logic [NUM_VTX*CW-1:0] out_Y,
    output logic [NUM_VTX*CW-1:0] out_Z,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_seq,
`ifdef XF_TIMEOUT_EN
    output logic                  xf_timeout,
`endif
    output logic                  overrun
);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(NUM_VTX);

    xf_state_e             state_q, state_d;
    coord_t                snap_c_q, snap_c_d;
    angle_t                snap_a_q, snap_a_d;
    logic [NUM_VTX*CW-1:0] snap_vx_q, snap_vx_d, snap_vy_q, snap_vy_d, snap_vz_q, snap_vz_d;
    logic [NUM_VTX*CW-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d, shadow_z_q, shadow_z_d;
    logic [NUM_VTX*CW-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic [CNTW-1:0]       issue_cnt_q, issue_cnt_d, collect_cnt_q, collect_cnt_d;
    logic                  err_seq_q, err_seq_d, overrun_q, overrun_d;
    logic                  res_hit, enter_done, wd_expire;

    assign enter_done = (state_q == RUN) && (collect_cnt_q == CNT_FULL);
    assign res_hit    = (state_q == RUN) && res_valid && (collect_cnt_q < issue_cnt_q)
                        && (res_idx == collect_cnt_q[IW-1:0]);

`ifdef XF_TIMEOUT_EN
    logic timeout_q, timeout_d;

    xf_watchdog #(.LIMIT(TO_CYC)) u_watchdog (
        .clk    (fclk),
        .rst_n  (rst_n),
        .enable (state_q == RUN),
        .clear  ((state_q != RUN) || res_hit),
        .expire (wd_expire)
    );

    assign xf_timeout = timeout_q;
    assign timeout_d  = timeout_q | wd_expire;
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            snap_c_q      <= '0;
            snap_a_q      <= '0;
            snap_vx_q     <= '0;
            snap_vy_q     <= '0;
            snap_vz_q     <= '0;
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            shadow_z_q    <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_z_q       <= '0;
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
            err_seq_q     <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef XF_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            snap_c_q      <= snap_c_d;
            snap_a_q      <= snap_a_d;
            snap_vx_q     <= snap_vx_d;
            snap_vy_q     <= snap_vy_d;
            snap_vz_q     <= snap_vz_d;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            shadow_z_q    <= shadow_z_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_z_q       <= out_z_d;
            issue_cnt_q   <= issue_cnt_d;
            collect_cnt_q <= collect_cnt_d;
            err_seq_q     <= err_seq_d;
            overrun_q     <= overrun_d;
`ifdef XF_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    // A watchdog abort returns to IDLE without publishing, so out_* keep the previous frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = RUN;
            RUN:     if (enter_done) state_d = DONE;
                     else if (wd_expire) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_c_d      = snap_c_q;
        snap_a_d      = snap_a_q;
        snap_vx_d     = snap_vx_q;
        snap_vy_d     = snap_vy_q;
        snap_vz_d     = snap_vz_q;
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        shadow_z_d    = shadow_z_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_z_d       = out_z_q;
        issue_cnt_d   = issue_cnt_q;
        collect_cnt_d = collect_cnt_q;
        err_seq_d     = err_seq_q;
        overrun_d     = overrun_q;

        if (xf_valid && xf_ready) begin
            issue_cnt_d = issue_cnt_q + CNTW'(1);
        end

        if (res_hit) begin
            shadow_x_d[res_idx*CW +: CW] = res_X;
            shadow_y_d[res_idx*CW +: CW] = res_Y;
            shadow_z_d[res_idx*CW +: CW] = res_Z;
            collect_cnt_d = collect_cnt_q + CNTW'(1);
        end else if (res_valid) begin
            err_seq_d = 1'b1;
        end

        if (enter_done) begin
            out_x_d = shadow_x_q;
            out_y_d = shadow_y_q;
            out_z_d = shadow_z_q;
        end

        if (frame_start && (state_q == IDLE)) begin
            snap_c_d      = '{x: Xc, y: Yc, z: Zc};
            snap_a_d      = '{x: angleX, y: angleY, z: angleZ};
            snap_vx_d     = vtx_X;
            snap_vy_d     = vtx_Y;
            snap_vz_d     = vtx_Z;
            issue_cnt_d   = '0;
            collect_cnt_d = '0;
        end else if (frame_start) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        xf_valid   = (state_q == RUN) && (issue_cnt_q < CNT_FULL);
        xf_idx     = '0;
        xf_vX      = '0;
        xf_vY      = '0;
        xf_vZ      = '0;
        if (xf_valid) begin
            xf_idx = issue_cnt_q[IW-1:0];
            xf_vX  = snap_vx_q[issue_cnt_q[IW-1:0]*CW +: CW];
            xf_vY  = snap_vy_q[issue_cnt_q[IW-1:0]*CW +: CW];
            xf_vZ  = snap_vz_q[issue_cnt_q[IW-1:0]*CW +: CW];
        end
        xf_cX      = snap_c_q.x;
        xf_cY      = snap_c_q.y;
        xf_cZ      = snap_c_q.z;
        xf_aX      = snap_a_q.x;
        xf_aY      = snap_a_q.y;
        xf_aZ      = snap_a_q.z;
        out_X      = out_x_q;
        out_Y      = out_y_q;
        out_Z      = out_z_q;
        frame_done = (state_q == DONE);
        busy       = (state_q != IDLE);
        err_seq    = err_seq_q;
        overrun    = overrun_q;
    end

endmodule
